minmax_stream_source: RTL
=========================

// Module: minmax_stream_source
// PURPOSE
//  Transmit side of the 4-bit min/max tracker interface: accepts framed samples from upstream via valid/ready,
//  buffers them in a small FIFO, and drives the tracker's clear / load / select / data strobes in protocol order.
//  Sits between a sample producer and the min/max tracker; one frame = clear, N loads, max query, min query.
// PARAMETERS
//  DW          4  sample width; matches tracker data bus
//  FIFO_DEPTH  4  input buffer entries; power of two, >= 2
//  CLR_CYCLES  1  cycles trk_clr is held high at frame start, 1..15
// PORTS
//  clock       in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high; all state cleared immediately
//  in_valid    in   1   upstream sample valid
//  in_ready    out  1   buffer can accept; = !fifo_full
//  in_data     in   DW  sample value
//  in_last     in   1   sample is last of frame
//  trk_clr     out  1   tracker clear strobe
//  trk_load    out  1   tracker load strobe; trk_d valid while high
//  trk_sel     out  1   query select: 1 = report max, 0 = report min (only meaningful in query states)
//  trk_d       out  DW  sample to tracker; 0 when trk_load low
//  busy        out  1   frame in progress (state != IDLE)
//  frame_done  out  1   one-cycle pulse after the min query
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, all trk_* = 0, busy = 0, frame_done = 0; in_ready = 1 after reset.
//  - Handshake: push when in_valid & in_ready; {in_last,in_data} stored; in_valid may drop anytime; no bypass.
//  - All trk_* outputs registered. Min latency accept -> trk_load = 2 cycles at idle (CLR_CYCLES=1).
//  - FSM:
//    IDLE   : FIFO non-empty -> CLEAR.
//    CLEAR  : trk_clr=1 for CLR_CYCLES cycles -> STREAM.
//    STREAM : FIFO non-empty: pop, trk_load=1, trk_d=data; popped last -> QMAX. FIFO empty: bubble (all 0), stay.
//    QMAX   : trk_sel=1 one cycle -> QMIN.   QMIN: trk_sel=0 one cycle -> DONE.
//    DONE   : frame_done=1 one cycle -> IDLE (re-enters CLEAR next cycle if FIFO non-empty).
//  - trk_clr and trk_load never high together; no load outside STREAM.
//  - FIFO accepts during every state; push and pop in same cycle allowed (count unchanged); push blocked when full
//    even if a pop occurs that cycle. Pointers wrap modulo FIFO_DEPTH.
//  - Single-sample frame (last on first word): CLEAR, one load, QMAX, QMIN, DONE.
//  - Reset mid-frame: FIFO flushed, outputs 0 asynchronously; next frame starts with a fresh CLEAR.
// CONFIGURATION
//  MINMAX_SHADOW_EN defined: adds outputs exp_max[DW-1:0], exp_min[DW-1:0], exp_valid. Shadow registers reset
//   on CLEAR entry (max=0, min=all ones), update unsigned on each load; exp_valid pulses with frame_done, holding
//   the frame's expected max/min for tracker self-check. Reset value 0/all-ones/0.
//  Undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package minmax_pkg: state enum (IDLE, CLEAR, STREAM, QMAX, QMIN, DONE), DW default, sel encoding
//   constants SEL_MAX=1 / SEL_MIN=0.
//  One sub-module: minmax_src_fifo (synchronous FIFO, DW+1 wide, async active-high reset, full/empty flags).
// TESTING
//  1 Reset then frame {3,9,1,last 7}: trk_clr 1 cycle, loads 3,9,1,7 on consecutive cycles, trk_sel 1 then 0,
//    frame_done pulse; with MINMAX_SHADOW_EN exp_max=9, exp_min=1.
//  2 Single sample {last 5}: clear, one load of 5, QMAX, QMIN, frame_done; shadow max=min=5.
//  3 Upstream gaps (in_valid every 3rd cycle): STREAM bubbles with trk_load=0, trk_d=0; no early query.
//  4 Burst 6 samples with FIFO_DEPTH=4 and stall: in_ready low when 4 held, no sample lost or duplicated.
//  5 Back-to-back frames {2,last 8},{last 4}: second CLEAR follows DONE; trk_clr/trk_load never overlap.
//  6 reset asserted mid-STREAM: outputs 0 same cycle, in_ready=1 after release, FIFO empty, next frame clean.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max tracker stream source.
// State encoding and query-select levels used by the source and its users.
package minmax_pkg;

   localparam int DW_DEF = 4;

   localparam logic SEL_MAX = 1'b1;
   localparam logic SEL_MIN = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      QMAX,
      QMIN,
      DONE
   } state_t;

endpackage

// File: rtl/minmax_src_fifo.sv
// Small synchronous FIFO with first-word fall-through read data and full/empty flags.
// Writes are refused when full and reads are ignored when empty.
module minmax_src_fifo #(
   parameter int W     = 5,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          wr_en;
   logic          rd_en;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign wr_en    = push & ~full;
   assign rd_en    = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/minmax_stream_source.sv
// Transmit side of the min/max tracker link: buffers framed samples and drives clear/load/query strobes.
// Optional expected max/min shadow outputs are enabled by defining MINMAX_SHADOW_EN.
module minmax_stream_source
   import minmax_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int CLR_CYCLES = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          trk_clr,
   output logic          trk_load,
   output logic          trk_sel,
   output logic [DW-1:0] trk_d,
   output logic          busy,
   output logic          frame_done
`ifdef MINMAX_SHADOW_EN
   ,
   output logic [DW-1:0] exp_max,
   output logic [DW-1:0] exp_min,
   output logic          exp_valid
`endif
);

   localparam logic [3:0] CLR_N = 4'(CLR_CYCLES);

   state_t        state;
   state_t        state_n;
   logic [3:0]    clr_cnt;
   logic [3:0]    clr_cnt_n;
   logic          last_seen;
   logic          last_seen_n;
   logic          clr_n;
   logic          load_n;
   logic          sel_n;
   logic          done_n;
   logic [DW-1:0] d_n;
   logic          take;
   logic          pop;
   logic          push;
   logic          fifo_full;
   logic          fifo_empty;
   logic [DW:0]   fifo_rd;

   assign in_ready = ~fifo_full;
   assign push     = in_valid & in_ready;
   assign busy     = (state != IDLE);

   minmax_src_fifo #(
      .W     (DW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data ({in_last, in_data}),
      .pop       (pop),
      .pop_data  (fifo_rd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // The state register names the phase whose strobes are on the pins this cycle,
   // so each transition also loads the strobe registers for the phase being entered.
   always_comb begin
      state_n     = state;
      clr_cnt_n   = clr_cnt;
      last_seen_n = last_seen;
      clr_n       = 1'b0;
      load_n      = 1'b0;
      sel_n       = SEL_MIN;
      done_n      = 1'b0;
      d_n         = '0;
      take        = 1'b0;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_n     = CLEAR;
               clr_n       = 1'b1;
               clr_cnt_n   = 4'd1;
               last_seen_n = 1'b0;
            end
         end
         CLEAR: begin
            if (clr_cnt >= CLR_N) begin
               state_n = STREAM;
               take    = 1'b1;
            end else begin
               clr_n     = 1'b1;
               clr_cnt_n = clr_cnt + 4'd1;
            end
         end
         STREAM: begin
            if (last_seen) begin
               state_n = QMAX;
               sel_n   = SEL_MAX;
            end else begin
               take = 1'b1;
            end
         end
         QMAX: begin
            state_n = QMIN;
            sel_n   = SEL_MIN;
         end
         QMIN: begin
            state_n = DONE;
            done_n  = 1'b1;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // An empty FIFO during streaming leaves a bubble with every strobe low.
      if (take && !fifo_empty) begin
         pop         = 1'b1;
         load_n      = 1'b1;
         d_n         = fifo_rd[DW-1:0];
         last_seen_n = fifo_rd[DW];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         clr_cnt    <= '0;
         last_seen  <= 1'b0;
         trk_clr    <= 1'b0;
         trk_load   <= 1'b0;
         trk_sel    <= 1'b0;
         trk_d      <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         clr_cnt    <= clr_cnt_n;
         last_seen  <= last_seen_n;
         trk_clr    <= clr_n;
         trk_load   <= load_n;
         trk_sel    <= sel_n;
         trk_d      <= d_n;
         frame_done <= done_n;
      end
   end

`ifdef MINMAX_SHADOW_EN
   logic shadow_clr;
   assign shadow_clr = (state == IDLE) && !fifo_empty;

   // Unsigned running max/min of the frame, restarted as the frame's clear begins.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         exp_max   <= '0;
         exp_min   <= '1;
         exp_valid <= 1'b0;
      end else begin
         exp_valid <= done_n;
         if (shadow_clr) begin
            exp_max <= '0;
            exp_min <= '1;
         end else if (pop) begin
            if (fifo_rd[DW-1:0] > exp_max) begin
               exp_max <= fifo_rd[DW-1:0];
            end
            if (fifo_rd[DW-1:0] < exp_min) begin
               exp_min <= fifo_rd[DW-1:0];
            end
         end
      end
   end
`endif

endmodule
